// File: rtl/delta_pkg.sv
// Constants and state type shared by the delta-modulation encoder and decoder.
package delta_pkg;

    localparam int DELTA_WIDTH = 8;
    localparam int DELTA_STEP  = 20;
    localparam int DELTA_MAX   = 127;
    localparam int DELTA_MIN   = -128;

    typedef enum logic [0:0] {
        IDLE,
        ENCODE
    } state_t;

endpackage

// File: rtl/delta_predictor.sv
// Predictor accumulator: steps by +/-STEP per enabled bit, with an optional overload guard.
module delta_predictor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 20,
    parameter bit          GUARD = 1'b1
) (
    input  logic                    CLK100MHZ,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    bit_in,
    output logic                    bit_out,
    output logic signed [WIDTH-1:0] predict
);

    localparam int unsigned PW   = WIDTH + 1;
    localparam int          HI_I = (2 ** (WIDTH - 1) - 1) - int'(STEP);
    localparam int          LO_I = -(2 ** (WIDTH - 1)) + int'(STEP);

    logic signed [WIDTH:0] hi_lim;
    logic signed [WIDTH:0] lo_lim;
    logic signed [WIDTH:0] step_ext;
    logic signed [WIDTH:0] p_ext;
    logic signed [WIDTH:0] p_next;

    assign hi_lim   = PW'(HI_I);
    assign lo_lim   = PW'(LO_I);
    assign step_ext = PW'(STEP);
    assign p_ext    = {predict[WIDTH-1], predict};

    // Guard flips the bit rather than saturating, so the decoder stays in lockstep.
    always_comb begin
        bit_out = bit_in;
        if (GUARD) begin
            if (bit_in && (p_ext > hi_lim)) begin
                bit_out = 1'b0;
            end else if (!bit_in && (p_ext < lo_lim)) begin
                bit_out = 1'b1;
            end
        end
        p_next = bit_out ? (p_ext + step_ext) : (p_ext - step_ext);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            predict <= '0;
        end else if (enable) begin
            predict <= p_next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/delta_encode.sv
// Delta-modulation encoder: accepts one signed sample, emits BITS_PER_SAMPLE up/down bits.
module delta_encode
    import delta_pkg::*;
#(
    parameter int unsigned WIDTH           = DELTA_WIDTH,
    parameter int unsigned STEP            = DELTA_STEP,
    parameter int unsigned BITS_PER_SAMPLE = 4,
    parameter int unsigned BIT_DIV         = 1
) (
    input  logic                    CLK100MHZ,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    encode,
    output logic                    bit_valid,
    output logic signed [WIDTH-1:0] predict
);

    state_t                  state_q;
    logic signed [WIDTH-1:0] sample_q;
    logic [7:0]              bit_cnt_q;
    logic [7:0]              div_cnt_q;
    logic                    fire;
    logic                    raw_bit;
    logic                    enc_bit;

    assign fire    = start && (state_q == ENCODE) && (div_cnt_q == 8'd0);
    assign raw_bit = sample_q > predict;

    delta_predictor #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .GUARD (1'b1)
    ) u_predictor (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .enable    (fire),
        .bit_in    (raw_bit),
        .bit_out   (enc_bit),
        .predict   (predict)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            encode       <= 1'b0;
            bit_valid    <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            bit_valid <= 1'b0;
            if (start) begin
                unique case (state_q)
                    IDLE: begin
                        if (sample_valid) begin
                            sample_q     <= sample_in;
                            div_cnt_q    <= 8'(BIT_DIV - 1);
                            bit_cnt_q    <= '0;
                            sample_ready <= 1'b0;
                            state_q      <= ENCODE;
                        end
                    end
                    ENCODE: begin
                        if (div_cnt_q == 8'd0) begin
                            encode    <= enc_bit;
                            bit_valid <= 1'b1;
                            div_cnt_q <= 8'(BIT_DIV - 1);
                            if (bit_cnt_q == 8'(BITS_PER_SAMPLE - 1)) begin
                                bit_cnt_q    <= '0;
                                sample_ready <= 1'b1;
                                state_q      <= IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 8'd1;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q - 8'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delta_encode.sv
// Bench for delta_encode: directed scenarios plus random traffic against a behavioural model.
module tb_delta_encode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: BIT_DIV=1, directed and random stimulus.
    logic              rst_a = 1'b1, start_a = 1'b0, valid_a = 1'b0;
    logic signed [7:0] sin_a = '0;
    logic              ready_a, enc_a, bv_a;
    logic signed [7:0] pred_a;

    // Instance B: BIT_DIV=3, looped back into a decoder model.
    logic              rst_b = 1'b1, start_b = 1'b0, valid_b = 1'b0;
    logic signed [7:0] sin_b = '0;
    logic              ready_b, enc_b, bv_b;
    logic signed [7:0] pred_b;
    bit                b_done = 1'b0;

    delta_encode #(.WIDTH(8), .STEP(20), .BITS_PER_SAMPLE(4), .BIT_DIV(1)) dut_a (
        .CLK100MHZ (clk), .reset (rst_a), .start (start_a), .sample_in (sin_a),
        .sample_valid (valid_a), .sample_ready (ready_a), .encode (enc_a),
        .bit_valid (bv_a), .predict (pred_a)
    );

    delta_encode #(.WIDTH(8), .STEP(20), .BITS_PER_SAMPLE(4), .BIT_DIV(3)) dut_b (
        .CLK100MHZ (clk), .reset (rst_b), .start (start_b), .sample_in (sin_b),
        .sample_valid (valid_b), .sample_ready (ready_b), .encode (enc_b),
        .bit_valid (bv_b), .predict (pred_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int p; int s; int left; int wt;
        bit busy; bit enc; bit bv; bit rdy;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.p = 0; m.s = 0; m.left = 0; m.wt = 0;
        m.busy = 0; m.enc = 0; m.bv = 0; m.rdy = 1;
        return m;
    endfunction

    // One clock of the encoder described in terms of samples, bits and the predictor value.
    function automatic mdl_t mdl_step(mdl_t m, bit rst, bit st, bit vld, int sin, int div, int bps);
        mdl_t n;
        bit   b;
        if (rst) return mdl_reset();
        n = m;
        n.bv = 0;
        if (!st) return n;
        if (!m.busy) begin
            if (vld) begin
                n.s = sin; n.busy = 1; n.rdy = 0; n.wt = div - 1; n.left = bps;
            end
        end else if (m.wt > 0) begin
            n.wt = m.wt - 1;
        end else begin
            b = (m.s > m.p);
            if (b && (m.p + 20 > 127)) b = 0;
            if (!b && (m.p - 20 < -128)) b = 1;
            n.p = b ? m.p + 20 : m.p - 20;
            n.enc = b; n.bv = 1; n.wt = div - 1; n.left = m.left - 1;
            if (n.left == 0) begin
                n.busy = 0; n.rdy = 1;
            end
        end
        return n;
    endfunction

    function automatic int wrap8(input int v);
        logic signed [7:0] t;
        t = 8'(v);
        return int'(t);
    endfunction

    mdl_t ma = mdl_reset();
    mdl_t mb = mdl_reset();
    int   dec_acc = 0;
    bit   rst_b_edge = 1'b1;
    bit   prev_bv_b = 1'b0;
    int   prev_pred_b = 0;

    always @(posedge clk) begin
        ma = mdl_step(ma, rst_a, start_a, valid_a, int'(sin_a), 1, 4);
        mb = mdl_step(mb, rst_b, start_b, valid_b, int'(sin_b), 3, 4);
        // Decoder partner: bit_valid drives its start, no overload guard, wraps like hardware.
        rst_b_edge = rst_b;
        if (rst_b) dec_acc = 0;
        else if (bv_b) dec_acc = wrap8(dec_acc + (enc_b ? 20 : -20));
    end

    always @(negedge clk) begin
        chk("a_ready", int'(ready_a), int'(ma.rdy));
        chk("a_bit_valid", int'(bv_a), int'(ma.bv));
        chk("a_encode", int'(enc_a), int'(ma.enc));
        chk("a_predict", int'(pred_a), ma.p);
        chk("b_ready", int'(ready_b), int'(mb.rdy));
        chk("b_bit_valid", int'(bv_b), int'(mb.bv));
        chk("b_encode", int'(enc_b), int'(mb.enc));
        chk("b_predict", int'(pred_b), mb.p);
        if (prev_bv_b && !rst_b_edge) chk("loopback_decoder", dec_acc, prev_pred_b);
        prev_bv_b   = bv_b;
        prev_pred_b = int'(pred_b);
    end

    task automatic send_a(input int s);
        int n = 0;
        while (!ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_a) chk("send_timeout", 0, 1);
        sin_a = 8'(s); valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic wait_bit(output int e, output int p);
        int n = 0;
        e = -1; p = 999;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bv_a) begin
                e = int'(enc_a); p = int'(pred_a);
                return;
            end
        end
        chk("bit_timeout", 0, 1);
    endtask

    task automatic pulse_reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    initial begin
        int e, p;
        int exp_e[12];
        int exp_p[12];
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(ready_a), 1);
        chk("reset_predict", int'(pred_a), 0);
        chk("reset_bit_valid", int'(bv_a), 0);
        rst_a = 1'b0; start_a = 1'b1;

        // Single sample of 60 from a zero predictor.
        exp_e[0:3] = '{1, 1, 1, 0};
        exp_p[0:3] = '{20, 40, 60, 40};
        send_a(60);
        chk("t1_ready_low", int'(ready_a), 0);
        for (int i = 0; i < 4; i++) begin
            wait_bit(e, p);
            chk("t1_encode", e, exp_e[i]);
            chk("t1_predict", p, exp_p[i]);
            if (i < 3) chk("t1_ready_busy", int'(ready_a), 0);
        end
        chk("t1_ready_back", int'(ready_a), 1);

        // Positive overload: climbs to 120 then alternates without wrapping.
        pulse_reset_a();
        exp_e = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1};
        exp_p = '{20, 40, 60, 80, 100, 120, 100, 120, 100, 120, 100, 120};
        for (int k = 0; k < 3; k++) begin
            send_a(127);
            for (int j = 0; j < 4; j++) begin
                wait_bit(e, p);
                chk("t2_encode", e, exp_e[k*4+j]);
                chk("t2_predict", p, exp_p[k*4+j]);
            end
        end

        // Negative overload: mirror image.
        pulse_reset_a();
        for (int k = 0; k < 3; k++) begin
            send_a(-128);
            for (int j = 0; j < 4; j++) begin
                wait_bit(e, p);
                chk("t3_encode", e, 1 - exp_e[k*4+j]);
                chk("t3_predict", p, -exp_p[k*4+j]);
            end
        end

        // Pause after the second bit of 60.
        pulse_reset_a();
        send_a(60);
        wait_bit(e, p);
        wait_bit(e, p);
        chk("t4_pre_predict", p, 40);
        start_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_paused_bv", int'(bv_a), 0);
            chk("t4_paused_predict", int'(pred_a), 40);
        end
        start_a = 1'b1;
        wait_bit(e, p);
        chk("t4_bit3", e, 1);
        chk("t4_pred3", p, 60);
        wait_bit(e, p);
        chk("t4_bit4", e, 0);
        chk("t4_pred4", p, 40);

        // Reset mid-sample, then -40 with a stray valid pulse during ENCODE.
        pulse_reset_a();
        send_a(60);
        wait_bit(e, p);
        wait_bit(e, p);
        pulse_reset_a();
        chk("t5_reset_predict", int'(pred_a), 0);
        chk("t5_reset_ready", int'(ready_a), 1);
        send_a(-40);
        sin_a = 8'sd100; valid_a = 1'b1;
        exp_e[0:3] = '{0, 0, 0, 1};
        exp_p[0:3] = '{-20, -40, -60, -40};
        for (int i = 0; i < 4; i++) begin
            wait_bit(e, p);
            valid_a = 1'b0;
            chk("t5_encode", e, exp_e[i]);
            chk("t5_predict", p, exp_p[i]);
        end

        // Random traffic on A, checked only by the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start_a = ($urandom_range(0, 9) != 0);
            valid_a = $urandom_range(0, 1);
            sin_a   = 8'($urandom);
            rst_a   = ($urandom_range(0, 199) == 0);
        end
        rst_a = 1'b0;

        for (int n = 0; n < 5000 && !b_done; n++) @(negedge clk);
        if (!b_done) chk("b_done_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_b = 1'b0; start_b = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            valid_b = $urandom_range(0, 1);
            sin_b   = 8'($urandom);
            rst_b   = ($urandom_range(0, 399) == 0);
        end
        rst_b = 1'b0;
        b_done = 1'b1;
    end

endmodule
